// File: rtl/ndn_ram_arb_pkg.sv
// Shared types and default widths for the content-RAM port arbiter.
// Optional statistics counters in the top are enabled by defining RAM_ARB_STATS_EN.
package ndn_ram_arb_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_BYTE_W = 10;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_t;

    typedef logic port_idx_t;

    localparam port_idx_t PORT0 = 1'b0;
    localparam port_idx_t PORT1 = 1'b1;

endpackage

// File: rtl/ram_arb_read_tracker.sv
// One-deep read tag pipeline: remembers which port issued a read so the
// RAM's 1-cycle-latency data is returned to that port on the next cycle.
module ram_arb_read_tracker
    import ndn_ram_arb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_issue,
    input  port_idx_t         i_port,
    input  logic [DATA_W-1:0] i_ram_q,
    output logic              o_rvalid0,
    output logic              o_rvalid1,
    output logic [DATA_W-1:0] o_rdata
);

    logic      r_vld;
    port_idx_t r_port;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld  <= 1'b0;
            r_port <= PORT0;
        end else begin
            r_vld  <= i_issue;
            r_port <= i_port;
        end
    end

    // Bus is forced to zero when no read is returning so it is quiet after reset.
    assign o_rvalid0 = r_vld && (r_port == PORT0);
    assign o_rvalid1 = r_vld && (r_port == PORT1);
    assign o_rdata   = r_vld ? i_ram_q : '0;

endmodule

// File: rtl/ram_port_arbiter.sv
// Burst-granular round-robin arbiter sharing the single-port content RAM between
// the PIT datapath (port 0) and the readout path (port 1). Macro RAM_ARB_STATS_EN adds grant/abort counters.
module ram_port_arbiter
    import ndn_ram_arb_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int BYTE_W    = DEF_BYTE_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MAX_BURST = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              last0,
    input  logic              last1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [BYTE_W-1:0] byte0,
    input  logic [BYTE_W-1:0] byte1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              burst_abort,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [BYTE_W-1:0] ram_byte,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_q
`ifdef RAM_ARB_STATS_EN
    ,
    output logic [15:0]       grant_cnt0,
    output logic [15:0]       grant_cnt1,
    output logic [7:0]        abort_cnt
`endif
);

    localparam int CNT_W = 10;
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(MAX_BURST - 1);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    port_idx_t         r_rr_last;
    logic [CNT_W-1:0]  r_beat_cnt;
    logic              r_abort;
    logic [ADDR_W-1:0] r_addr_hold;
    logic [BYTE_W-1:0] r_byte_hold;
    logic [DATA_W-1:0] r_data_hold;

    port_idx_t         w_sel;
    logic              w_accept;
    logic              w_last;
    logic              w_wd;
    logic              w_end;
    logic              w_grant0;
    logic              w_grant1;
    logic              w_port_we;
    logic [ADDR_W-1:0] w_port_addr;
    logic [BYTE_W-1:0] w_port_byte;
    logic [DATA_W-1:0] w_port_data;

    always_comb begin
        w_state_nxt = r_state;
        w_sel       = PORT0;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        w_grant0    = 1'b0;
        w_grant1    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req0 && req1) begin
                    if (r_rr_last == PORT1) w_grant0 = 1'b1;
                    else                    w_grant1 = 1'b1;
                end else if (req0) begin
                    w_grant0 = 1'b1;
                end else if (req1) begin
                    w_grant1 = 1'b1;
                end
            end
            ST_OWN0: begin
                w_sel    = PORT0;
                w_accept = req0;
                w_last   = last0;
            end
            ST_OWN1: begin
                w_sel    = PORT1;
                w_accept = req1;
                w_last   = last1;
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // Watchdog fires when this beat would be the MAX_BURST-th without last.
        w_wd  = w_accept && !w_last && (r_beat_cnt == WD_LAST);
        w_end = w_accept && (w_last || w_wd);

        if (w_end) begin
            w_state_nxt = ST_IDLE;
            if (w_sel == PORT0 && req1) w_grant1 = 1'b1;
            if (w_sel == PORT1 && req0) w_grant0 = 1'b1;
        end
        if (w_grant0) w_state_nxt = ST_OWN0;
        if (w_grant1) w_state_nxt = ST_OWN1;
    end

    assign w_port_we   = (w_sel == PORT1) ? we1    : we0;
    assign w_port_addr = (w_sel == PORT1) ? addr1  : addr0;
    assign w_port_byte = (w_sel == PORT1) ? byte1  : byte0;
    assign w_port_data = (w_sel == PORT1) ? wdata1 : wdata0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_rr_last   <= PORT1;
            r_beat_cnt  <= '0;
            r_abort     <= 1'b0;
            r_addr_hold <= '0;
            r_byte_hold <= '0;
            r_data_hold <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_abort <= w_wd;
            if (w_end) r_rr_last <= w_sel;
            if (w_grant0 || w_grant1) r_beat_cnt <= '0;
            else if (w_accept)        r_beat_cnt <= r_beat_cnt + 1'b1;
            if (w_accept) begin
                r_addr_hold <= w_port_addr;
                r_byte_hold <= w_port_byte;
                r_data_hold <= w_port_data;
            end
        end
    end

    // RAM fields pass through during an accepted beat and otherwise hold the last beat.
    assign ram_we      = w_accept && w_port_we;
    assign ram_addr    = w_accept ? w_port_addr : r_addr_hold;
    assign ram_byte    = w_accept ? w_port_byte : r_byte_hold;
    assign ram_data    = w_accept ? w_port_data : r_data_hold;
    assign gnt0        = (r_state == ST_OWN0);
    assign gnt1        = (r_state == ST_OWN1);
    assign burst_abort = r_abort;

    ram_arb_read_tracker #(
        .DATA_W (DATA_W)
    ) u_read_tracker (
        .clk       (clk),
        .rst       (rst),
        .i_issue   (w_accept && !w_port_we),
        .i_port    (w_sel),
        .i_ram_q   (ram_q),
        .o_rvalid0 (rvalid0),
        .o_rvalid1 (rvalid1),
        .o_rdata   (rdata)
    );

`ifdef RAM_ARB_STATS_EN
    logic [15:0] r_grant_cnt0;
    logic [15:0] r_grant_cnt1;
    logic [7:0]  r_abort_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant_cnt0 <= '0;
            r_grant_cnt1 <= '0;
            r_abort_cnt  <= '0;
        end else begin
            if (w_grant0 && r_grant_cnt0 != '1) r_grant_cnt0 <= r_grant_cnt0 + 1'b1;
            if (w_grant1 && r_grant_cnt1 != '1) r_grant_cnt1 <= r_grant_cnt1 + 1'b1;
            if (r_abort && r_abort_cnt != '1)   r_abort_cnt  <= r_abort_cnt + 1'b1;
        end
    end

    assign grant_cnt0 = r_grant_cnt0;
    assign grant_cnt1 = r_grant_cnt1;
    assign abort_cnt  = r_abort_cnt;
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter (MAX_BURST=4) with a behavioural 1-cycle RAM.
// Works with or without RAM_ARB_STATS_EN defined.
module tb_ram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, last0, last1, we0, we1;
    logic [9:0]  addr0, addr1, byte0, byte1;
    logic [7:0]  wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1, burst_abort, ram_we;
    logic [7:0]  rdata, ram_data, ram_q;
    logic [9:0]  ram_addr, ram_byte;
`ifdef RAM_ARB_STATS_EN
    logic [15:0] grant_cnt0, grant_cnt1;
    logic [7:0]  abort_cnt;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ram_port_arbiter #(
        .ADDR_W(10), .BYTE_W(10), .DATA_W(8), .MAX_BURST(4)
    ) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .last0(last0), .last1(last1),
        .we0(we0), .we1(we1), .addr0(addr0), .addr1(addr1),
        .byte0(byte0), .byte1(byte1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .burst_abort(burst_abort),
        .ram_addr(ram_addr), .ram_byte(ram_byte), .ram_data(ram_data),
        .ram_we(ram_we), .ram_q(ram_q)
`ifdef RAM_ARB_STATS_EN
        , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1), .abort_cnt(abort_cnt)
`endif
    );

    logic [7:0] mem [int];
    int ram_key;
    always_comb ram_key = int'({ram_addr, ram_byte});

    always @(posedge clk) begin
        ram_q <= mem.exists(ram_key) ? mem[ram_key] : 8'h00;
        if (ram_we) mem[ram_key] = ram_data;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req0 = 0; req1 = 0; last0 = 0; last1 = 0; we0 = 0; we1 = 0;
        addr0 = 0; addr1 = 0; byte0 = 0; byte1 = 0; wdata0 = 0; wdata1 = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        step();
        step();
        checks++;
        if ({gnt0, gnt1, rvalid0, rvalid1, burst_abort, ram_we} !== 6'b0) begin
            errors++; $display("FAIL reset_ctrl got=%b exp=000000", {gnt0, gnt1, rvalid0, rvalid1, burst_abort, ram_we});
        end
        checks++;
        if ({rdata, ram_addr, ram_byte, ram_data} !== 36'h0) begin
            errors++; $display("FAIL reset_data got=%h exp=0", {rdata, ram_addr, ram_byte, ram_data});
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single();
        req0 = 1; we0 = 1; addr0 = 3; byte0 = 0; wdata0 = 8'hA0; last0 = 0;
        #1;
        checks++;
        if (gnt0 !== 1'b0 || ram_we !== 1'b0) begin
            errors++; $display("FAIL single_pregrant got gnt0=%b ram_we=%b exp=0,0", gnt0, ram_we);
        end
        step();
        for (int i = 0; i < 4; i++) begin
            byte0 = 10'(i); wdata0 = 8'hA0 + 8'(i); last0 = (i == 3);
            #1;
            checks++;
            if (gnt0 !== 1'b1 || ram_we !== 1'b1) begin
                errors++; $display("FAIL single_beat%0d_gnt got gnt0=%b ram_we=%b exp=1,1", i, gnt0, ram_we);
            end
            checks++;
            if (ram_addr !== 10'd3 || ram_byte !== 10'(i) || ram_data !== 8'hA0 + 8'(i)) begin
                errors++; $display("FAIL single_beat%0d_fields got a=%0d b=%0d d=%h exp=3,%0d,%h",
                                   i, ram_addr, ram_byte, ram_data, i, 8'hA0 + 8'(i));
            end
            step();
        end
        req0 = 0; last0 = 0;
        #1;
        checks++;
        if (gnt0 !== 1'b0 || ram_we !== 1'b0 || ram_byte !== 10'd3) begin
            errors++; $display("FAIL single_after got gnt0=%b ram_we=%b byte=%0d exp=0,0,3", gnt0, ram_we, ram_byte);
        end
    endtask

    task automatic test_contention();
        rst = 1; step(); rst = 0; step();
        req0 = 1; req1 = 1; we0 = 1; we1 = 1; addr0 = 1; addr1 = 2;
        byte0 = 0; byte1 = 0; last0 = 0; last1 = 0;
        step();
        checks++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || ram_addr !== 10'd1) begin
            errors++; $display("FAIL cont_first got gnt0=%b gnt1=%b addr=%0d exp=1,0,1", gnt0, gnt1, ram_addr);
        end
        step();
        byte0 = 1; last0 = 1;
        step();
        checks++;
        if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin
            errors++; $display("FAIL cont_handover got gnt0=%b gnt1=%b exp=0,1", gnt0, gnt1);
        end
        req0 = 0; last0 = 0;
        #1;
        checks++;
        if (ram_we !== 1'b1 || ram_addr !== 10'd2) begin
            errors++; $display("FAIL cont_port1_beat got ram_we=%b addr=%0d exp=1,2", ram_we, ram_addr);
        end
        step();
        byte1 = 1; last1 = 1;
        step();
        req1 = 0; last1 = 0;
        #1;
        checks++;
        if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
            errors++; $display("FAIL cont_idle got gnt0=%b gnt1=%b exp=0,0", gnt0, gnt1);
        end
        // lone port-0 burst leaves port 0 as the last served
        req0 = 1; last0 = 1;
        step();
        step();
        req0 = 0; last0 = 0;
        step();
        req0 = 1; req1 = 1;
        step();
        checks++;
        if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin
            errors++; $display("FAIL cont_rr_second got gnt0=%b gnt1=%b exp=0,1", gnt0, gnt1);
        end
        last1 = 1;
        step();
        checks++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
            errors++; $display("FAIL cont_rr_then0 got gnt0=%b gnt1=%b exp=1,0", gnt0, gnt1);
        end
        req1 = 0; last1 = 0; last0 = 1;
        step();
        clear_inputs();
        step();
    endtask

    task automatic test_reads();
        logic [7:0] exp_q [3];
        exp_q[0] = 8'h11; exp_q[1] = 8'h22; exp_q[2] = 8'h33;
        for (int i = 0; i < 3; i++) mem[int'({10'd5, 10'(i)})] = exp_q[i];
        req1 = 1; we1 = 0; addr1 = 5; byte1 = 0; last1 = 0;
        step();
        checks++;
        if (gnt1 !== 1'b1 || rvalid1 !== 1'b0) begin
            errors++; $display("FAIL read_grant got gnt1=%b rvalid1=%b exp=1,0", gnt1, rvalid1);
        end
        for (int i = 0; i < 3; i++) begin
            byte1 = 10'(i); last1 = (i == 2);
            step();
            checks++;
            if (rvalid1 !== 1'b1 || rvalid0 !== 1'b0 || rdata !== exp_q[i]) begin
                errors++; $display("FAIL read_data%0d got rv1=%b rv0=%b rdata=%h exp=1,0,%h",
                                   i, rvalid1, rvalid0, rdata, exp_q[i]);
            end
        end
        clear_inputs();
        step();
        checks++;
        if (rvalid1 !== 1'b0 || rvalid0 !== 1'b0) begin
            errors++; $display("FAIL read_end got rv1=%b rv0=%b exp=0,0", rvalid1, rvalid0);
        end
    endtask

    task automatic test_stall();
        req0 = 1; req1 = 1; we0 = 1; we1 = 1; addr0 = 7; addr1 = 8;
        step();
        checks++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
            errors++; $display("FAIL stall_grant got gnt0=%b gnt1=%b exp=1,0", gnt0, gnt1);
        end
        byte0 = 0; step();
        byte0 = 1; step();
        req0 = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || ram_we !== 1'b0) begin
                errors++; $display("FAIL stall_cycle%0d got gnt0=%b gnt1=%b ram_we=%b exp=1,0,0", i, gnt0, gnt1, ram_we);
            end
            step();
        end
        req0 = 1; byte0 = 2;
        #1;
        checks++;
        if (ram_we !== 1'b1 || ram_byte !== 10'd2) begin
            errors++; $display("FAIL stall_resume got ram_we=%b byte=%0d exp=1,2", ram_we, ram_byte);
        end
        step();
        byte0 = 3; last0 = 1;
        step();
        checks++;
        if (gnt1 !== 1'b1 || burst_abort !== 1'b0) begin
            errors++; $display("FAIL stall_full_burst got gnt1=%b abort=%b exp=1,0", gnt1, burst_abort);
        end
        req0 = 0; last0 = 0; last1 = 1;
        step();
        clear_inputs();
        checks++;
        if (burst_abort !== 1'b0 || gnt1 !== 1'b0) begin
            errors++; $display("FAIL stall_release got abort=%b gnt1=%b exp=0,0", burst_abort, gnt1);
        end
    endtask

    task automatic test_watchdog();
        req0 = 1; req1 = 1; we0 = 1; we1 = 1; last0 = 0; last1 = 0;
        step();
        for (int i = 0; i < 4; i++) begin
            byte0 = 10'(i);
            #1;
            checks++;
            if (gnt0 !== 1'b1 || burst_abort !== 1'b0) begin
                errors++; $display("FAIL wd_beat%0d got gnt0=%b abort=%b exp=1,0", i, gnt0, burst_abort);
            end
            step();
        end
        checks++;
        if (gnt0 !== 1'b0 || gnt1 !== 1'b1 || burst_abort !== 1'b1) begin
            errors++; $display("FAIL wd_release got gnt0=%b gnt1=%b abort=%b exp=0,1,1", gnt0, gnt1, burst_abort);
        end
        last1 = 1;
        step();
        checks++;
        if (burst_abort !== 1'b0 || gnt0 !== 1'b1) begin
            errors++; $display("FAIL wd_pulse_once got abort=%b gnt0=%b exp=0,1", burst_abort, gnt0);
        end
`ifdef RAM_ARB_STATS_EN
        checks++;
        if (abort_cnt !== 8'd1) begin
            errors++; $display("FAIL wd_abort_cnt got=%0d exp=1", abort_cnt);
        end
`endif
        req1 = 0; last1 = 0; byte0 = 4; last0 = 1;
        step();
        clear_inputs();
        step();
        checks++;
        if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
            errors++; $display("FAIL wd_idle got gnt0=%b gnt1=%b exp=0,0", gnt0, gnt1);
        end
    endtask

    task automatic test_reset_mid_read();
        req1 = 1; we1 = 0; addr1 = 5; byte1 = 1; last1 = 1;
        step();
        rst = 1;
        #1;
        checks++;
        if (gnt1 !== 1'b0 || ram_addr !== 10'd0 || rvalid1 !== 1'b0) begin
            errors++; $display("FAIL rst_mid_async got gnt1=%b addr=%0d rv1=%b exp=0,0,0", gnt1, ram_addr, rvalid1);
        end
        step();
        checks++;
        if (rvalid1 !== 1'b0 || rdata !== 8'h00) begin
            errors++; $display("FAIL rst_mid_norvalid got rv1=%b rdata=%h exp=0,00", rvalid1, rdata);
        end
`ifdef RAM_ARB_STATS_EN
        checks++;
        if (grant_cnt0 !== 16'd0 || grant_cnt1 !== 16'd0 || abort_cnt !== 8'd0) begin
            errors++; $display("FAIL rst_counters got g0=%0d g1=%0d ab=%0d exp=0,0,0", grant_cnt0, grant_cnt1, abort_cnt);
        end
`endif
        rst = 0;
        clear_inputs();
        step();
        checks++;
        if (rvalid1 !== 1'b0 || gnt1 !== 1'b0) begin
            errors++; $display("FAIL rst_mid_after got rv1=%b gnt1=%b exp=0,0", rvalid1, gnt1);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_reads();
        test_stall();
        test_watchdog();
        test_reset_mid_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
